// File: rtl/post_adder_accum_if.sv
// ---------------------------------------------------------------------------
// post_adder_accum_if
//   Bundles the operand, control and result signals of the post-adder /
//   accumulator slice so that it can be connected as one port.
//
//   Operands : m_in[35:0], dab_in[47:0], c_in[47:0], pcin[47:0], carryin
//   Control  : opmode[4:0] ([1:0] X sel, [3:2] Z sel, [4] subtract),
//              ce_opmode, ce_p, ce_carryout, vld_in
//   Results  : p[47:0], pcout[47:0], carryout, vld_out
//
//   slave  : the slice itself (takes operands/control, drives results)
//   master : whatever feeds the slice
// ---------------------------------------------------------------------------
interface post_adder_accum_if;
  logic [35:0] m_in;
  logic [47:0] dab_in;
  logic [47:0] c_in;
  logic [47:0] pcin;
  logic        carryin;
  logic [4:0]  opmode;
  logic        ce_opmode;
  logic        ce_p;
  logic        ce_carryout;
  logic        vld_in;
  logic [47:0] p;
  logic [47:0] pcout;
  logic        carryout;
  logic        vld_out;

  modport slave (
    input  m_in, dab_in, c_in, pcin, carryin, opmode,
           ce_opmode, ce_p, ce_carryout, vld_in,
    output p, pcout, carryout, vld_out
  );

  modport master (
    output m_in, dab_in, c_in, pcin, carryin, opmode,
           ce_opmode, ce_p, ce_carryout, vld_in,
    input  p, pcout, carryout, vld_out
  );
endinterface

// File: rtl/post_adder_accum.sv
// ---------------------------------------------------------------------------
// post_adder_accum
//   48-bit post-adder / accumulator slice. Two operands are picked by the
//   X and Z multiplexers, combined as Z + X + carryin or Z - (X + carryin)
//   in 49-bit arithmetic, and the low 48 bits feed the P register while bit
//   48 feeds the carry-out register.
//
//   Parameters
//     OPMODEREG   : 1 = opmode comes from the OPMODE register, 0 = direct
//     PREG        : 1 = p/pcout/vld_out registered, 0 = combinational
//     CARRYOUTREG : 1 = carryout registered, 0 = combinational
//
//   Ports
//     clk : rising-edge clock for every register
//     rst : asynchronous, active-low clear of OPMODE, P, CYO and VLD
//     bus : slave side of post_adder_accum_if (operands, enables, results)
// ---------------------------------------------------------------------------
module post_adder_accum #(
  parameter int OPMODEREG   = 1,
  parameter int PREG        = 1,
  parameter int CARRYOUTREG = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  post_adder_accum_if.slave     bus
);

  logic [4:0]  opmode_q, opmode_d;
  logic [47:0] p_q, p_d;
  logic        cyo_q, cyo_d;
  logic        vld_q, vld_d;

  logic [4:0]  op_eff;
  logic [47:0] x_mux;
  logic [47:0] z_mux;
  logic [48:0] sum;

  generate
    if (OPMODEREG == 1) begin : g_opreg
      assign op_eff = opmode_q;
    end else begin : g_opdirect
      assign op_eff = bus.opmode;
    end
  endgenerate

  // Feedback selections always read p_q, never the output port, so the
  // unregistered configuration has no combinational loop through the adder.
  always_comb begin
    x_mux = 48'd0;
    case (op_eff[1:0])
      2'd0:    x_mux = 48'd0;
      2'd1:    x_mux = {12'd0, bus.m_in};
      2'd2:    x_mux = p_q;
      default: x_mux = bus.dab_in;
    endcase
  end

  always_comb begin
    z_mux = 48'd0;
    case (op_eff[3:2])
      2'd0:    z_mux = 48'd0;
      2'd1:    z_mux = bus.pcin;
      2'd2:    z_mux = p_q;
      default: z_mux = bus.c_in;
    endcase
  end

  // Carry-in belongs to the subtrahend, so subtraction is Z - (X + cin);
  // bit 48 then reads as a borrow.
  always_comb begin
    sum = 49'd0;
    if (op_eff[4]) begin
      sum = {1'b0, z_mux} - ({1'b0, x_mux} + {48'd0, bus.carryin});
    end else begin
      sum = {1'b0, z_mux} + {1'b0, x_mux} + {48'd0, bus.carryin};
    end
  end

  always_comb begin
    opmode_d = bus.ce_opmode   ? bus.opmode : opmode_q;
    p_d      = bus.ce_p        ? sum[47:0]  : p_q;
    vld_d    = bus.ce_p        ? bus.vld_in : vld_q;
    cyo_d    = bus.ce_carryout ? sum[48]    : cyo_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opmode_q <= 5'd0;
      p_q      <= 48'd0;
      cyo_q    <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      opmode_q <= opmode_d;
      p_q      <= p_d;
      cyo_q    <= cyo_d;
      vld_q    <= vld_d;
    end
  end

  generate
    if (PREG == 1) begin : g_preg
      assign bus.p       = p_q;
      assign bus.pcout   = p_q;
      assign bus.vld_out = vld_q;
    end else begin : g_pcomb
      assign bus.p       = sum[47:0];
      assign bus.pcout   = sum[47:0];
      assign bus.vld_out = bus.vld_in;
    end

    if (CARRYOUTREG == 1) begin : g_cyreg
      assign bus.carryout = cyo_q;
    end else begin : g_cycomb
      assign bus.carryout = sum[48];
    end
  endgenerate

endmodule

// File: tb/tb_post_adder_accum.sv
// ---------------------------------------------------------------------------
// tb_post_adder_accum
//   Drives a fully registered slice (u_dut_reg) and a fully combinational
//   slice (u_dut_comb) from the same stimulus. Directed table vectors and
//   hand-written sequences target the registered slice; a randomized phase
//   checks both against a signed-integer reference model.
// ---------------------------------------------------------------------------
module tb_post_adder_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [35:0] m_in;
  logic [47:0] dab_in, c_in, pcin;
  logic        carryin;
  logic [4:0]  opmode;
  logic        ce_opmode, ce_p, ce_carryout, vld_in;

  post_adder_accum_if ifa ();
  post_adder_accum_if ifb ();

  assign ifa.m_in = m_in;        assign ifb.m_in = m_in;
  assign ifa.dab_in = dab_in;    assign ifb.dab_in = dab_in;
  assign ifa.c_in = c_in;        assign ifb.c_in = c_in;
  assign ifa.pcin = pcin;        assign ifb.pcin = pcin;
  assign ifa.carryin = carryin;  assign ifb.carryin = carryin;
  assign ifa.opmode = opmode;    assign ifb.opmode = opmode;
  assign ifa.ce_opmode = ce_opmode;     assign ifb.ce_opmode = ce_opmode;
  assign ifa.ce_p = ce_p;               assign ifb.ce_p = ce_p;
  assign ifa.ce_carryout = ce_carryout; assign ifb.ce_carryout = ce_carryout;
  assign ifa.vld_in = vld_in;           assign ifb.vld_in = vld_in;

  post_adder_accum u_dut_reg (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  post_adder_accum #(
    .OPMODEREG   (0),
    .PREG        (0),
    .CARRYOUTREG (0)
  ) u_dut_comb (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain signed integer arithmetic on the selected operands.
  function automatic void ref_calc(input logic [4:0] op, input logic [35:0] m,
                                   input logic [47:0] dab, input logic [47:0] c,
                                   input logic [47:0] pc, input logic [47:0] pfb,
                                   input logic cin,
                                   output logic [47:0] r, output logic cy);
    longint xv, zv, t;
    case (op[1:0])
      2'd0: xv = 0;
      2'd1: xv = longint'(m);
      2'd2: xv = longint'(pfb);
      default: xv = longint'(dab);
    endcase
    case (op[3:2])
      2'd0: zv = 0;
      2'd1: zv = longint'(pc);
      2'd2: zv = longint'(pfb);
      default: zv = longint'(c);
    endcase
    if (op[4]) begin
      t  = zv - xv - longint'(cin);
      cy = (t < 0);
    end else begin
      t  = zv + xv + longint'(cin);
      cy = (t >= 64'sh1_0000_0000_0000);
    end
    r = t[47:0];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [35:0] m;
    logic [47:0] dab;
    logic [47:0] c;
    logic [47:0] pc;
    logic        cin;
    logic        vld;
    logic [47:0] exp_p;
    logic        exp_cy;
    logic        exp_vld;
  } vec_t;

  vec_t tbl [10];

  // Reference model state for the registered slice and the P register of
  // the combinational slice.
  logic [4:0]  a_op;
  logic [47:0] a_p, b_p, ar, br;
  logic        a_cy, a_vld, acy, bcy;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{5'b01101, 36'd100, 48'd0, 48'd23, 48'd0, 1'b1, 1'b1, 48'd124, 1'b0, 1'b1};
    tbl[1] = '{5'b11101, 36'd3, 48'd0, 48'd10, 48'd0, 1'b1, 1'b1, 48'd6, 1'b0, 1'b1};
    tbl[2] = '{5'b11101, 36'd20, 48'd0, 48'd10, 48'd0, 1'b1, 1'b1, 48'hFFFF_FFFF_FFF5, 1'b1, 1'b1};
    tbl[3] = '{5'b00111, 36'd0, 48'h1234_5678_9ABC, 48'd0, 48'h1111_1111_1111, 1'b0, 1'b1,
               48'h2345_6789_ABCD, 1'b0, 1'b1};
    tbl[4] = '{5'b01111, 36'd0, 48'hFFFF_FFFF_FFFF, 48'd1, 48'd0, 1'b0, 1'b1, 48'd0, 1'b1, 1'b1};
    tbl[5] = '{5'b00000, 36'd0, 48'd0, 48'd0, 48'd0, 1'b1, 1'b1, 48'd1, 1'b0, 1'b1};
    tbl[6] = '{5'b10000, 36'd0, 48'd0, 48'd0, 48'd0, 1'b0, 1'b1, 48'd0, 1'b0, 1'b1};
    tbl[7] = '{5'b10000, 36'd0, 48'd0, 48'd0, 48'd0, 1'b1, 1'b1, 48'hFFFF_FFFF_FFFF, 1'b1, 1'b1};
    tbl[8] = '{5'b01001, 36'd7, 48'd0, 48'd0, 48'd0, 1'b0, 1'b1, 48'd7, 1'b0, 1'b1};
    tbl[9] = '{5'b01101, 36'hF_FFFF_FFFF, 48'd0, 48'd1, 48'd0, 1'b1, 1'b0,
               48'h10_0000_0001, 1'b0, 1'b0};

    rst = 1'b0;
    m_in = '0; dab_in = '0; c_in = '0; pcin = '0; carryin = 1'b0;
    opmode = '0; ce_opmode = 1'b1; ce_p = 1'b1; ce_carryout = 1'b1; vld_in = 1'b1;

    // Held in reset: everything reads zero.
    @(negedge clk);
    @(negedge clk);
    chk("reset_p", ifa.p, 48'd0);
    chk("reset_pcout", ifa.pcout, 48'd0);
    chk("reset_cy", ifa.carryout, 1'b0);
    chk("reset_vld", ifa.vld_out, 1'b0);
    $display("reset: p=%h cy=%b vld=%b", ifa.p, ifa.carryout, ifa.vld_out);

    // Table vectors: opmode loads on the first edge (P held), result on the second.
    for (int i = 0; i < 10; i++) begin
      do_reset();
      opmode = tbl[i].op; m_in = tbl[i].m; dab_in = tbl[i].dab; c_in = tbl[i].c;
      pcin = tbl[i].pc; carryin = tbl[i].cin; vld_in = tbl[i].vld;
      ce_opmode = 1'b1; ce_p = 1'b0; ce_carryout = 1'b1;
      @(negedge clk);
      ce_p = 1'b1;
      @(negedge clk);
      chk($sformatf("tbl%0d_p", i), ifa.p, tbl[i].exp_p);
      chk($sformatf("tbl%0d_pcout", i), ifa.pcout, tbl[i].exp_p);
      chk($sformatf("tbl%0d_cy", i), ifa.carryout, tbl[i].exp_cy);
      chk($sformatf("tbl%0d_vld", i), ifa.vld_out, tbl[i].exp_vld);
      $display("tbl%0d: op=%b p=%h cy=%b vld=%b", i, tbl[i].op, ifa.p, ifa.carryout, ifa.vld_out);
    end

    // Accumulate m_in=5, freeze with ce_p=0, resume, then async reset.
    do_reset();
    opmode = 5'b01001; m_in = 36'd5; carryin = 1'b0; vld_in = 1'b1;
    ce_opmode = 1'b1; ce_p = 1'b0; ce_carryout = 1'b1;
    @(negedge clk);
    ce_p = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("acc%0d_p", i), ifa.p, 48'(5 * i));
      chk($sformatf("acc%0d_vld", i), ifa.vld_out, 1'b1);
      $display("acc%0d: p=%0d vld=%b", i, ifa.p, ifa.vld_out);
    end
    ce_p = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_p", i), ifa.p, 48'd20);
      $display("hold%0d: p=%0d", i, ifa.p);
    end
    ce_p = 1'b1;
    @(negedge clk);
    chk("resume_p", ifa.p, 48'd25);
    $display("resume: p=%0d", ifa.p);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_p", ifa.p, 48'd0);
    chk("async_rst_vld", ifa.vld_out, 1'b0);
    chk("async_rst_cy", ifa.carryout, 1'b0);
    $display("async reset: p=%h vld=%b", ifa.p, ifa.vld_out);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_p", ifa.p, 48'd0);
    chk("post_rst_vld", ifa.vld_out, 1'b1);
    @(negedge clk);
    chk("post_rst_acc_p", ifa.p, 48'd5);
    $display("post reset: p=%0d", ifa.p);

    // Opmode change with simultaneous ce_p: old opmode governs this edge,
    // new one the next; the next edge also wraps P modulo 2^48.
    do_reset();
    opmode = 5'b00011; dab_in = 48'd1; carryin = 1'b0;
    ce_opmode = 1'b1; ce_p = 1'b0; ce_carryout = 1'b1;
    @(negedge clk);
    ce_p = 1'b1;
    @(negedge clk);
    chk("load_p", ifa.p, 48'd1);
    opmode = 5'b01001; dab_in = 48'hFFFF_FFFF_FFFF; m_in = 36'd1;
    @(negedge clk);
    chk("opchg_old_p", ifa.p, 48'hFFFF_FFFF_FFFF);
    chk("opchg_old_cy", ifa.carryout, 1'b0);
    @(negedge clk);
    chk("wrap_p", ifa.p, 48'd0);
    chk("wrap_cy", ifa.carryout, 1'b1);
    $display("wrap: p=%h cy=%b", ifa.p, ifa.carryout);

    // Randomized phase against the reference model, both configurations.
    do_reset();
    a_op = '0; a_p = '0; a_cy = 1'b0; a_vld = 1'b0; b_p = '0;
    for (int n = 0; n < 300; n++) begin
      chk("rnd_a_p", ifa.p, a_p);
      chk("rnd_a_pcout", ifa.pcout, a_p);
      chk("rnd_a_cy", ifa.carryout, a_cy);
      chk("rnd_a_vld", ifa.vld_out, a_vld);
      opmode      = 5'($urandom);
      m_in        = ($urandom_range(0, 3) == 0) ? 36'($urandom_range(0, 15)) : 36'({$urandom, $urandom});
      dab_in      = 48'({$urandom, $urandom});
      c_in        = 48'({$urandom, $urandom});
      pcin        = 48'({$urandom, $urandom});
      carryin     = 1'($urandom);
      vld_in      = 1'($urandom);
      ce_opmode   = ($urandom_range(0, 3) != 0);
      ce_p        = ($urandom_range(0, 3) != 0);
      ce_carryout = ($urandom_range(0, 3) != 0);
      #1;
      ref_calc(opmode, m_in, dab_in, c_in, pcin, b_p, carryin, br, bcy);
      chk("rnd_b_p", ifb.p, br);
      chk("rnd_b_pcout", ifb.pcout, br);
      chk("rnd_b_cy", ifb.carryout, bcy);
      chk("rnd_b_vld", ifb.vld_out, vld_in);
      ref_calc(a_op, m_in, dab_in, c_in, pcin, a_p, carryin, ar, acy);
      $display("rnd%0d: op=%b a_p=%h b_p=%h", n, opmode, ifa.p, ifb.p);
      @(posedge clk);
      if (ce_opmode) a_op = opmode;
      if (ce_p) begin
        a_p   = ar;
        a_vld = vld_in;
        b_p   = br;
      end
      if (ce_carryout) a_cy = acy;
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
